// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: multiplexes push writes and refill reads
// onto one RAM access per cycle, and keeps the head word in a registered output slot.
module ram_fifo_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] Depth = (AW+1)'(2 ** AW);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mem_count_q, mem_count_d;
  logic             last_rd_q, last_rd_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic slot_free;
  logic grant_rd;
  logic do_wr;

  // Arbitration uses only registered state and rd_ready, so wr_ready never depends on wr_valid.
  // While the output slot streams, last_rd forces reads and writes to alternate.
  always_comb begin
    slot_free = !rd_valid_q || rd_ready;
    grant_rd  = (mem_count_q != '0) && slot_free && (!rd_valid_q || !last_rd_q);
    wr_ready  = (mem_count_q != Depth) && !grant_rd;
    do_wr     = wr_valid && wr_ready;
    ram_addr  = grant_rd ? rd_ptr_q : wr_ptr_q;
    ram_we    = do_wr;
    ram_wdata = wr_data;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    last_rd_d   = grant_rd;

    if (do_wr) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      mem_count_d = mem_count_q + 1'b1;
    end

    if (grant_rd) begin
      rd_data_d   = ram_rdata;
      rd_valid_d  = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
      mem_count_d = mem_count_q - 1'b1;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      last_rd_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      last_rd_q   <= last_rd_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = mem_count_q + (AW+1)'(rd_valid_q);
  assign full     = (mem_count_q == Depth);
  assign empty    = (count == '0);

endmodule
